// File: rtl/mem_responder.sv
// Test-harness memory responder for the val/rdy mem-message interface.
// Requests access a word array at acceptance. Responses travel through a
// fixed-latency pipeline into an in-order response FIFO that absorbs
// backpressure. A backdoor port loads program images one word at a time.
module mem_responder #(
    parameter int p_opaque_bits = 8,
    parameter int p_num_words   = 256,
    parameter int p_latency     = 2,
    parameter int p_depth       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic                     req_op,
    input  logic [p_opaque_bits-1:0] req_opaque,
    input  logic [31:0]              req_addr,
    input  logic [1:0]               req_len,
    input  logic [31:0]              req_data,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     resp_op,
    output logic [p_opaque_bits-1:0] resp_opaque,
    output logic [1:0]               resp_len,
    output logic [31:0]              resp_data,
    input  logic                     init_en,
    input  logic [31:0]              init_addr,
    input  logic [31:0]              init_data
);

    localparam int AW   = $clog2(p_num_words);
    localparam int IW   = 1 + p_opaque_bits + 2 + 32;
    localparam int CW   = $clog2(p_depth + 1);
    localparam int PW   = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int NREG = (p_latency > 1) ? p_latency - 1 : 1;

    // Handshake semantics: a transfer happens on any posedge where val && rdy.
    // The responder holds resp_* stable while resp_val && !resp_rdy.

    logic [31:0]    mem_q [p_num_words];
    logic [NREG-1:0] pipe_vld_q;
    logic [IW-1:0]  pipe_q [NREG];
    logic [IW-1:0]  fifo_q [p_depth];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  out_q, out_d;

    logic           accept;
    logic           deq;
    logic           enq_vld;
    logic [IW-1:0]  enq_item;
    logic [IW-1:0]  new_item;
    logic [AW-1:0]  req_idx;
    logic [AW-1:0]  init_idx;
    logic [31:0]    rd_word;
    logic [31:0]    rd_data;
    logic [31:0]    wr_word;
    logic           unused_bits;

    assign unused_bits = ^{req_addr[31:2+AW], init_addr[31:2+AW], init_addr[1:0]};

    assign req_idx  = req_addr[2 +: AW];
    assign init_idx = init_addr[2 +: AW];
    assign rd_word  = mem_q[req_idx];

    // Outstanding is registered, so a response dequeue frees a slot one cycle later
    assign req_rdy  = rst && (out_q < CW'(p_depth));
    assign accept   = req_val && req_rdy;
    assign resp_val = rst && (cnt_q != '0);
    assign deq      = resp_val && resp_rdy;

    assign {resp_op, resp_opaque, resp_len, resp_data} = fifo_q[rd_ptr_q];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(p_depth - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Extract the addressed lanes of the current word and build the merged write word
    always_comb begin
        rd_data = rd_word;
        wr_word = rd_word;
        case (req_len)
            2'd1: begin
                rd_data = {24'b0, rd_word[{req_addr[1:0], 3'b000} +: 8]};
                wr_word[{req_addr[1:0], 3'b000} +: 8] = req_data[7:0];
            end
            2'd2: begin
                rd_data = {16'b0, rd_word[{req_addr[1], 4'b0000} +: 16]};
                wr_word[{req_addr[1], 4'b0000} +: 16] = req_data[15:0];
            end
            default: begin
                rd_data = rd_word;
                wr_word = req_data;
            end
        endcase
    end

    // Writes report zero data; reads carry the value sampled at acceptance
    assign new_item = {req_op, req_opaque, req_len, (req_op ? 32'b0 : rd_data)};

    assign enq_vld  = (p_latency == 1) ? accept   : pipe_vld_q[NREG-1];
    assign enq_item = (p_latency == 1) ? new_item : pipe_q[NREG-1];

    // Memory array: backdoor first so a same-word request write overrides it
    always_ff @(posedge clk) begin
        if (init_en) mem_q[init_idx] <= init_data;
        if (accept && req_op) mem_q[req_idx] <= wr_word;
    end

    // Latency pipeline valid bits; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= accept;
            for (int k = 1; k < NREG; k++) pipe_vld_q[k] <= pipe_vld_q[k-1];
        end
    end

    // Latency pipeline payload shifts every cycle alongside its valid bit
    always_ff @(posedge clk) begin
        pipe_q[0] <= new_item;
        for (int k = 1; k < NREG; k++) pipe_q[k] <= pipe_q[k-1];
    end

    // Next-state for FIFO pointers, occupancy and outstanding count
    always_comb begin
        wr_ptr_d = enq_vld ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        case ({enq_vld, deq})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        case ({accept, deq})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase
    end

    // Response FIFO storage; cannot overflow since outstanding bounds occupancy
    always_ff @(posedge clk) begin
        if (enq_vld) fifo_q[wr_ptr_q] <= enq_item;
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios with a
// scoreboard of expected response data, tag and arrival cycle.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    logic        req_op;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_data;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_op;
    logic [7:0]  resp_opaque;
    logic [1:0]  resp_len;
    logic [31:0] resp_data;
    logic        init_en;
    logic [31:0] init_addr;
    logic [31:0] init_data;

    mem_responder #(
        .p_opaque_bits(8),
        .p_num_words(256),
        .p_latency(2),
        .p_depth(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op),
        .req_opaque(req_opaque), .req_addr(req_addr), .req_len(req_len),
        .req_data(req_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op),
        .resp_opaque(resp_opaque), .resp_len(resp_len), .resp_data(resp_data),
        .init_en(init_en), .init_addr(init_addr), .init_data(init_data)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  exp_tag_q[$];
    int          exp_cyc_q[$];
    logic [31:0] mdl [256];
    bit          last_ok;
    int          n_acc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic void model_write(input logic [31:0] addr, input logic [1:0] len,
                                        input logic [31:0] d);
        logic [31:0] mask;
        int          sh;
        int          w;
        w = int'(addr[9:2]);
        case (len)
            2'd1:    begin sh = 8 * int'(addr[1:0]); mask = 32'hFF << sh; end
            2'd2:    begin sh = 16 * int'(addr[1]); mask = 32'hFFFF << sh; end
            default: begin sh = 0; mask = 32'hFFFF_FFFF; end
        endcase
        mdl[w] = (mdl[w] & ~mask) | ((d << sh) & mask);
    endfunction

    // Monitor: compare every response handshake against the scoreboard head
    always @(negedge clk) begin : monitor
        logic [31:0] d;
        logic [7:0]  t;
        int          c;
        if (rst && resp_val && resp_rdy) begin
            if (exp_q.size() == 0) begin
                check("stale_resp", 32'd1, 32'd0);
            end else begin
                d = exp_q.pop_front();
                t = exp_tag_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("resp_data", resp_data, d);
                check("resp_tag", {24'b0, resp_opaque}, {24'b0, t});
                if (c >= 0) check("resp_latency", 32'(cyc), 32'(c));
            end
        end
    end

    // Driver tasks start and end one time unit after a posedge
    task automatic init_word(input logic [31:0] addr, input logic [31:0] d);
        init_en = 1'b1; init_addr = addr; init_data = d;
        mdl[addr[9:2]] = d;
        @(posedge clk); #1;
        init_en = 1'b0;
    endtask

    task automatic send(input logic op, input logic [31:0] addr, input logic [1:0] len,
                        input logic [31:0] wdata, input logic [7:0] tag,
                        input logic [31:0] exp, input bit lat_chk,
                        input int max_wait, input bit must);
        req_val = 1'b1; req_op = op; req_addr = addr; req_len = len;
        req_data = wdata; req_opaque = tag;
        last_ok = 1'b0;
        for (int i = 0; i < max_wait && !last_ok; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                last_ok = 1'b1;
                exp_q.push_back(exp);
                exp_tag_q.push_back(tag);
                exp_cyc_q.push_back(lat_chk ? cyc + 2 : -1);
                if (op) model_write(addr, len, wdata);
            end
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        if (!last_ok && must) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
        rst = 1'b0; req_val = 1'b0; req_op = 1'b0; req_opaque = '0;
        req_addr = '0; req_len = '0; req_data = '0; resp_rdy = 1'b1;
        init_en = 1'b0; init_addr = '0; init_data = '0;

        // Reset state, with backdoor loads issued while reset is held
        repeat (2) @(posedge clk);
        #1;
        init_word(32'h14, 32'hDEAD_BEEF);
        init_word(32'h20, 32'h0);
        init_word(32'h40, 32'h0);
        for (int i = 0; i < 8; i++) init_word(32'h80 + 32'(4 * i), $urandom);
        @(negedge clk);
        check("rst_req_rdy", {31'b0, req_rdy}, 32'd0);
        check("rst_resp_val", {31'b0, resp_val}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_req_rdy", {31'b0, req_rdy}, 32'd1);
        @(posedge clk); #1;

        // Word round trip with latency check
        send(1'b0, 32'h14, 2'd0, 32'h0, 8'h03, 32'hDEAD_BEEF, 1'b1, 20, 1'b1);
        drain();

        // Byte and halfword lanes
        send(1'b1, 32'h21, 2'd1, 32'hFFFF_FFAA, 8'h60, 32'h0, 1'b1, 20, 1'b1);
        send(1'b1, 32'h22, 2'd2, 32'hFFFF_1234, 8'h61, 32'h0, 1'b1, 20, 1'b1);
        send(1'b0, 32'h20, 2'd0, 32'h0, 8'h62, 32'h1234_AA00, 1'b1, 20, 1'b1);
        send(1'b0, 32'h21, 2'd1, 32'h0, 8'h63, 32'h0000_00AA, 1'b1, 20, 1'b1);
        send(1'b0, 32'h23, 2'd2, 32'h0, 8'h64, 32'h0000_1234, 1'b1, 20, 1'b1);
        drain();

        // Throughput: back-to-back reads, one response per cycle
        for (int i = 0; i < 8; i++)
            send(1'b0, 32'h80 + 32'(4 * i), 2'd0, 32'h0, 8'h10 + 8'(i), mdl[32 + i], 1'b1, 20, 1'b1);
        drain();

        // Backpressure: only p_depth requests accepted while responses stall
        resp_rdy = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 32'h80 + 32'(4 * i), 2'd0, 32'h0, 8'h20 + 8'(i), mdl[32 + i], 1'b0, 2, 1'b0);
            if (last_ok) n_acc++;
        end
        check("bp_accepted", 32'(n_acc), 32'd4);
        @(negedge clk);
        check("bp_req_rdy_low", {31'b0, req_rdy}, 32'd0);
        check("bp_head_data", resp_data, mdl[32]);
        @(negedge clk);
        check("bp_head_hold", resp_data, mdl[32]);
        check("bp_head_tag", {24'b0, resp_opaque}, 32'h20);
        @(posedge clk); #1;
        resp_rdy = 1'b1;
        @(negedge clk);
        check("bp_rdy_same_cycle", {31'b0, req_rdy}, 32'd0);
        @(negedge clk);
        check("bp_rdy_next_cycle", {31'b0, req_rdy}, 32'd1);
        @(posedge clk); #1;
        drain();

        // Reset mid-operation drops pending responses
        resp_rdy = 1'b0;
        for (int i = 0; i < 3; i++)
            send(1'b0, 32'h14, 2'd0, 32'h0, 8'h30 + 8'(i), 32'hDEAD_BEEF, 1'b0, 20, 1'b1);
        rst = 1'b0;
        exp_q.delete(); exp_tag_q.delete(); exp_cyc_q.delete();
        @(negedge clk);
        check("mid_rst_resp_val", {31'b0, resp_val}, 32'd0);
        check("mid_rst_req_rdy", {31'b0, req_rdy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        resp_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", {31'b0, resp_val}, 32'd0);
            @(posedge clk); #1;
        end

        // Memory survives reset; high address bits wrap
        send(1'b0, 32'h14, 2'd0, 32'h0, 8'h40, 32'hDEAD_BEEF, 1'b1, 20, 1'b1);
        send(1'b0, 32'h414, 2'd0, 32'h0, 8'h41, 32'hDEAD_BEEF, 1'b1, 20, 1'b1);
        drain();

        // Read/write ordering on one word
        send(1'b0, 32'h40, 2'd0, 32'h0, 8'h50, 32'h0, 1'b1, 20, 1'b1);
        send(1'b1, 32'h40, 2'd0, 32'h55, 8'h51, 32'h0, 1'b1, 20, 1'b1);
        send(1'b0, 32'h40, 2'd0, 32'h0, 8'h52, 32'h0000_0055, 1'b1, 20, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
